// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative 32-step multiply/divide unit
// that owns the HI/LO registers and stalls upstream through busy.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        valid_in,
    input  logic [4:0]  alu_op_in,
    input  logic [31:0] operand_a_in,
    input  logic [31:0] operand_b_in,
    input  logic [4:0]  shamt_in,
    input  logic        is_mem_in,
    input  logic        is_int_wb_in,
    input  logic [4:0]  int_wb_address_in,
    output logic        is_mem_out,
    output logic        is_int_wb_out,
    output logic [4:0]  int_wb_address_out,
    output logic [31:0] int_wb_value_out,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_wh, r_wl, r_op2, r_a;
    logic        r_neg_q, r_neg_r, r_div0, r_busy;

    logic        w_accept, w_is_mdu, w_signed, w_last;
    logic [31:0] w_res, w_abs_a, w_abs_b;
    logic [32:0] w_mul_sum, w_div_sh;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [31:0] w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;
    logic [63:0] w_prod;

    assign busy     = r_busy;
    assign w_accept = valid_in & ~r_busy;
    assign w_is_mdu = (alu_op_in >= 5'd14) && (alu_op_in <= 5'd17);
    assign w_signed = ~alu_op_in[0];
    assign w_last   = (r_state != S_IDLE) && (r_cnt == 5'd31);
    assign w_abs_a  = (w_signed && operand_a_in[31]) ? -operand_a_in : operand_a_in;
    assign w_abs_b  = (w_signed && operand_b_in[31]) ? -operand_b_in : operand_b_in;

    always_comb begin
        w_res = '0;
        case (alu_op_in)
            5'd0:  w_res = operand_a_in + operand_b_in;
            5'd1:  w_res = operand_a_in - operand_b_in;
            5'd2:  w_res = operand_a_in & operand_b_in;
            5'd3:  w_res = operand_a_in | operand_b_in;
            5'd4:  w_res = operand_a_in ^ operand_b_in;
            5'd5:  w_res = ~(operand_a_in | operand_b_in);
            5'd6:  w_res = ($signed(operand_a_in) < $signed(operand_b_in)) ? 32'd1 : 32'd0;
            5'd7:  w_res = (operand_a_in < operand_b_in) ? 32'd1 : 32'd0;
            5'd8:  w_res = operand_b_in << shamt_in;
            5'd9:  w_res = operand_b_in >> shamt_in;
            5'd10: w_res = $signed(operand_b_in) >>> shamt_in;
            5'd11: w_res = {operand_b_in[15:0], 16'h0};
            5'd12: w_res = r_hi;
            5'd13: w_res = r_lo;
            default: w_res = '0;
        endcase
    end

    // MUL: {r_wh,r_wl} is the shift-add product register; DIV: r_wh is the
    // partial remainder and r_wl shifts dividend bits out / quotient bits in.
    assign w_mul_sum  = r_wl[0] ? ({1'b0, r_wh} + {1'b0, r_op2}) : {1'b0, r_wh};
    assign w_div_sh   = {r_wh, r_wl[31]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_op2};
    assign w_div_diff = w_div_sh[31:0] - r_op2;

    always_comb begin
        w_step_hi = r_wh;
        w_step_lo = r_wl;
        if (r_state == S_MUL) begin
            w_step_hi = w_mul_sum[32:1];
            w_step_lo = {w_mul_sum[0], r_wl[31:1]};
        end else if (r_state == S_DIV) begin
            w_step_hi = w_div_ge ? w_div_diff : w_div_sh[31:0];
            w_step_lo = {r_wl[30:0], w_div_ge};
        end
    end

    assign w_prod = r_neg_q ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};

    always_comb begin
        w_fin_hi = w_prod[63:32];
        w_fin_lo = w_prod[31:0];
        if (r_state == S_DIV) begin
            w_fin_lo = r_div0 ? '1   : (r_neg_q ? -w_step_lo : w_step_lo);
            w_fin_hi = r_div0 ? r_a  : (r_neg_r ? -w_step_hi : w_step_hi);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mdu) w_state_nxt = alu_op_in[4] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_busy             <= 1'b0;
            r_cnt              <= '0;
            r_hi               <= '0;
            r_lo               <= '0;
            r_wh               <= '0;
            r_wl               <= '0;
            r_op2              <= '0;
            r_a                <= '0;
            r_neg_q            <= 1'b0;
            r_neg_r            <= 1'b0;
            r_div0             <= 1'b0;
            is_mem_out         <= 1'b0;
            is_int_wb_out      <= 1'b0;
            int_wb_address_out <= '0;
            int_wb_value_out   <= '0;
        end else if (!halt) begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_accept && !w_is_mdu) begin
                is_mem_out         <= is_mem_in;
                is_int_wb_out      <= is_int_wb_in;
                int_wb_address_out <= int_wb_address_in;
                int_wb_value_out   <= w_res;
            end else begin
                is_mem_out         <= 1'b0;
                is_int_wb_out      <= 1'b0;
                int_wb_address_out <= '0;
                int_wb_value_out   <= '0;
            end
            if (r_state == S_IDLE) begin
                if (w_accept && w_is_mdu) begin
                    r_cnt   <= '0;
                    r_wh    <= '0;
                    r_wl    <= w_abs_a;
                    r_op2   <= w_abs_b;
                    r_a     <= operand_a_in;
                    r_neg_q <= w_signed & (operand_a_in[31] ^ operand_b_in[31]);
                    r_neg_r <= w_signed & operand_a_in[31];
                    r_div0  <= (operand_b_in == '0);
                end
            end else begin
                r_cnt <= r_cnt + 5'd1;
                r_wh  <= w_step_hi;
                r_wl  <= w_step_lo;
                if (w_last) begin
                    r_hi <= w_fin_hi;
                    r_lo <= w_fin_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU vectors, bubbles, halt,
// MDU latency/results and asynchronous reset during a divide.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        halt = 1'b0;
    logic        valid_in = 1'b0;
    logic [4:0]  alu_op_in = '0;
    logic [31:0] operand_a_in = '0;
    logic [31:0] operand_b_in = '0;
    logic [4:0]  shamt_in = '0;
    logic        is_mem_in = 1'b0;
    logic        is_int_wb_in = 1'b0;
    logic [4:0]  int_wb_address_in = '0;
    logic        is_mem_out, is_int_wb_out, busy;
    logic [4:0]  int_wb_address_out;
    logic [31:0] int_wb_value_out;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage u_dut (
        .clk                (clk),
        .reset              (rst_n),
        .halt               (halt),
        .valid_in           (valid_in),
        .alu_op_in          (alu_op_in),
        .operand_a_in       (operand_a_in),
        .operand_b_in       (operand_b_in),
        .shamt_in           (shamt_in),
        .is_mem_in          (is_mem_in),
        .is_int_wb_in       (is_int_wb_in),
        .int_wb_address_in  (int_wb_address_in),
        .is_mem_out         (is_mem_out),
        .is_int_wb_out      (is_int_wb_out),
        .int_wb_address_out (int_wb_address_out),
        .int_wb_value_out   (int_wb_value_out),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl_word();
        return {25'b0, is_mem_out, is_int_wb_out, int_wb_address_out};
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic mem, input logic wb, input logic [4:0] addr);
        valid_in          = 1'b1;
        alu_op_in         = op;
        operand_a_in      = a;
        operand_b_in      = b;
        shamt_in          = sh;
        is_mem_in         = mem;
        is_int_wb_in      = wb;
        int_wb_address_in = addr;
    endtask

    // One accepted single-cycle instruction, checked one edge later.
    task automatic sc(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input logic mem,
                      input logic wb, input logic [4:0] addr, input logic [31:0] exp);
        drive(op, a, b, sh, mem, wb, addr);
        @(posedge clk); #1;
        check(tag, int_wb_value_out, exp);
        check({tag, "_ctl"}, ctl_word(), {25'b0, mem, wb, addr});
    endtask

    task automatic mdu(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int halt_at,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   n;
        logic bad;
        drive(op, a, b, 5'd0, 1'b0, 1'b1, 5'd3);
        @(posedge clk); #1;
        check({tag, "_acc_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_acc_val"}, int_wb_value_out, 32'd0);
        check({tag, "_acc_ctl"}, ctl_word(), 32'd0);
        drive(5'd13, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0, 1'b1, 5'd7);
        n   = 0;
        bad = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (halt_at != 0 && n == halt_at) halt = 1'b1;
            if (halt_at != 0 && n == halt_at + 5) halt = 1'b0;
            if (busy === 1'b1 && (int_wb_value_out !== 32'd0 || ctl_word() !== 32'd0)) bad = 1'b1;
        end
        halt = 1'b0;
        check({tag, "_busy_len"}, n, (halt_at != 0) ? 32'd37 : 32'd32);
        check({tag, "_bubbles"}, {31'b0, bad}, 32'd0);
        sc({tag, "_mflo"}, 5'd13, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 5'd7, exp_lo);
        sc({tag, "_mfhi"}, 5'd12, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 5'd8, exp_hi);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_val", int_wb_value_out, 32'd0);
        check("rst_ctl", ctl_word(), 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        drive(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b1, 5'd5);
        #10 rst_n = 1'b1;

        // First edge after reset release must accept the waiting ADD.
        @(posedge clk); #1;
        check("add_wrap", int_wb_value_out, 32'h8000_0000);
        check("add_ctl", ctl_word(), {25'b0, 1'b0, 1'b1, 5'd5});

        sc("sub_wrap", 5'd1,  32'd0,         32'd1,         5'd0,  1'b0, 1'b1, 5'd1,  32'hFFFF_FFFF);
        sc("and",      5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  1'b0, 1'b1, 5'd2,  32'hF000_F000);
        sc("or",       5'd3,  32'h0F0F_0000, 32'h0000_00F0, 5'd0,  1'b1, 1'b0, 5'd3,  32'h0F0F_00F0);
        sc("xor",      5'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  1'b0, 1'b1, 5'd4,  32'hF0F0_0F0F);
        sc("nor",      5'd5,  32'h0000_FFFF, 32'h00FF_0000, 5'd0,  1'b0, 1'b1, 5'd6,  32'hFF00_0000);
        sc("slt",      5'd6,  32'hFFFF_FFFF, 32'd1,         5'd0,  1'b0, 1'b1, 5'd9,  32'd1);
        sc("sltu",     5'd7,  32'hFFFF_FFFF, 32'd1,         5'd0,  1'b0, 1'b1, 5'd10, 32'd0);
        sc("sll",      5'd8,  32'd0,         32'd1,         5'd31, 1'b0, 1'b1, 5'd11, 32'h8000_0000);
        sc("srl",      5'd9,  32'd0,         32'h8000_0000, 5'd31, 1'b0, 1'b1, 5'd12, 32'd1);
        sc("sra",      5'd10, 32'd0,         32'h8000_0010, 5'd4,  1'b0, 1'b1, 5'd13, 32'hF800_0001);
        sc("lui",      5'd11, 32'd0,         32'h5555_ABCD, 5'd0,  1'b0, 1'b1, 5'd14, 32'hABCD_0000);
        sc("op20",     5'd20, 32'h1234_5678, 32'h1,         5'd0,  1'b0, 1'b1, 5'd15, 32'd0);
        sc("lui2",     5'd11, 32'd0,         32'h0000_1357, 5'd0,  1'b1, 1'b1, 5'd16, 32'h1357_0000);

        // Halt with a valid instruction: nothing accepted, outputs hold.
        drive(5'd0, 32'd1, 32'd1, 5'd0, 1'b0, 1'b1, 5'd20);
        halt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("halt_val", int_wb_value_out, 32'h1357_0000);
        check("halt_ctl", ctl_word(), {25'b0, 1'b1, 1'b1, 5'd16});
        halt = 1'b0;
        valid_in = 1'b0;
        @(posedge clk); #1;
        check("bubble_val", int_wb_value_out, 32'd0);
        check("bubble_ctl", ctl_word(), 32'd0);

        mdu("mult",   5'd14, 32'hFFFF_FFFD, 32'd7,         0,  32'hFFFF_FFEB, 32'hFFFF_FFFF);
        mdu("mult_h", 5'd14, 32'hFFFF_FFFD, 32'd7,         10, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
        mdu("multu",  5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  32'h0000_0001, 32'hFFFF_FFFE);
        mdu("div",    5'd16, 32'hFFFF_FFF9, 32'd2,         0,  32'hFFFF_FFFD, 32'hFFFF_FFFF);
        mdu("divu0",  5'd17, 32'd9,         32'd0,         0,  32'hFFFF_FFFF, 32'd9);
        mdu("div0n",  5'd16, 32'hFFFF_FFFB, 32'd0,         0,  32'hFFFF_FFFF, 32'hFFFF_FFFB);
        mdu("divovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0,  32'h8000_0000, 32'd0);
        mdu("divu",   5'd17, 32'd100,       32'd7,         0,  32'd14,        32'd2);

        // Reset in the middle of a divide; HI/LO currently hold divu's 2/14.
        drive(5'd16, 32'd1000, 32'd3, 5'd0, 1'b0, 1'b1, 5'd3);
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_val", int_wb_value_out, 32'd0);
        check("rst_mid_ctl", ctl_word(), 32'd0);
        #2 rst_n = 1'b1;
        sc("rst_mfhi", 5'd12, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 5'd1, 32'd0);
        sc("rst_mflo", 5'd13, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 5'd2, 32'd0);
        sc("post_add", 5'd0,  32'd40, 32'd2, 5'd0, 1'b0, 1'b1, 5'd4, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as follows:
  - clk  input  1  rising-edge clock.
  - reset  input  1  asynchronous, active-low reset.
REQ-002 SHALL provide the following ports:
  - halt  input  1  global freeze, 1 = hold all state.
  - valid_in  input  1  instruction present on the inputs.
  - alu_op_in  input  5  operation select (REQ-010).
  - operand_a_in  input  32  rs value.
  - operand_b_in  input  32  rt value or immediate.
  - shamt_in  input  5  shift amount.
  - is_mem_in  input  1  instruction is a memory access.
  - is_int_wb_in  input  1  instruction writes an integer register.
  - int_wb_address_in  input  5  destination register.
  - is_mem_out  output  1  registered to the MA stage.
  - is_int_wb_out  output  1  registered to the MA stage.
  - int_wb_address_out  output  5  registered to the MA stage.
  - int_wb_value_out  output  32  registered result.
  - busy  output  1  registered; 1 = multiply/divide unit (MDU) is iterating and the inputs are not consumed.

Function
REQ-010 alu_op encoding SHALL be:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
  - 12 MFHI, 13 MFLO, 14 MULT, 15 MULTU, 16 DIV, 17 DIVU.
  - 18-31: result 0.
REQ-011 ADD and SUB SHALL wrap modulo 2^32, with no overflow flag or trap.
REQ-012 SLT and SLTU SHALL produce 32'd1 or 32'd0 (signed and unsigned compare respectively).
REQ-013 Shifts SHALL shift operand_b by shamt_in; SRA SHALL sign-fill.
REQ-014 LUI SHALL produce {operand_b[15:0], 16'h0}.
REQ-015 Single-cycle ops (0-13) SHALL have 1-cycle latency:
  - Output registers load on the edge where valid_in=1, busy=0 and halt=0.
  - is_mem, is_int_wb and address pass through unchanged.
REQ-016 On any edge with halt=0 and no instruction accepted (valid_in=0 or busy=1), outputs SHALL load a bubble: is_mem_out=0, is_int_wb_out=0, address=0, value=0.
REQ-017 While halt=1, all outputs, the FSM, the iteration counter, HI and LO SHALL hold.
REQ-018 MDU FSM states SHALL be IDLE, MUL and DIV.
REQ-019 IDLE->MUL or IDLE->DIV SHALL occur on accepting op 14-15 or 16-17:
  - Operands latch and counter=0.
  - busy=1 from the next cycle.
  - The output registers load a bubble, regardless of is_int_wb_in.
REQ-020 MUL and DIV SHALL each perform 32 iterations (one per non-halted cycle), then write HI/LO and return to IDLE.
  - busy is high for exactly 32 non-halted cycles.
REQ-021 MULT/MULTU SHALL produce the 64-bit signed/unsigned product, with HI=[63:32] and LO=[31:0].
REQ-022 DIV/DIVU SHALL produce LO=quotient and HI=remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
REQ-023 Divisor 0 SHALL give HI=operand_a and LO=32'hFFFFFFFF for both DIV and DIVU.
REQ-024 DIV 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-025 MFHI and MFLO SHALL return HI/LO as updated by any previously completed MDU op.
  - An MDU op's writeback occurs on the same edge busy falls, so an MFHI presented during busy reads the new value.
REQ-026 While busy=1, the inputs SHALL be ignored; upstream holds its instruction until busy=0.
REQ-027 valid_in=1 with halt=1 SHALL NOT be accepted.

Reset
REQ-030 Reset assertion SHALL asynchronously force the following, including mid-iteration:
  - is_mem_out=0, is_int_wb_out=0, int_wb_address_out=0, int_wb_value_out=0.
  - busy=0, FSM=IDLE, counter=0, HI=0, LO=0.
REQ-031 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-040 ADD: a=32'h7FFFFFFF, b=1, wb=1, addr=5 -> next edge value=32'h80000000, addr=5, is_int_wb_out=1.
REQ-041 SRA: b=32'h80000010, shamt=4 -> value=32'hF8000001.
REQ-042 MULT a=-3, b=7, then MFLO and MFHI held in the inputs:
  - busy high for 32 cycles, with bubbles on the outputs.
  - MFLO then returns 32'hFFFFFFEB and MFHI returns 32'hFFFFFFFF.
REQ-043 DIV a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
  - DIVU a=9, b=0 -> LO=32'hFFFFFFFF, HI=9.
REQ-044 halt=1 for 5 cycles starting at MULT iteration 10:
  - Outputs and counter frozen throughout.
  - busy falls 37 cycles after accept.
  - Product is correct.
REQ-045 Reset pulsed at DIV iteration 20 -> busy=0 and HI=LO=0 immediately; the next ADD executes normally.
